credit_vc_outport: RTL and testbench

//  Next-generation router output port: credit-based flow control per downstream VC,

---
 rtl/credit_vc_outport.sv | 171 +++++++++++++++++
 tb/tb_credit_vc_outport.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_vc_outport.sv
// Router output port: per-VC credit counters, round-robin switch allocation and a packet lock
// per downstream VC, with wormhole or virtual-cut-through admission of head flits.
module credit_vc_outport #(
  parameter int unsigned no_inport                   = 7,
  parameter int unsigned floorplusone_log2_no_inport = 3,
  parameter int unsigned no_vc                       = 4,
  parameter int unsigned floorplusone_log2_no_vc     = 3,
  parameter int unsigned phit_size                   = 32,
  parameter int unsigned buf_size                    = 4,
  parameter int unsigned floorplusone_log2_buf_size  = 3,
  parameter int unsigned switching_method            = 3
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [no_inport-1:0]                         req_vec,
  input  logic [no_inport*floorplusone_log2_no_vc-1:0] req_vc_vec,
  input  logic [no_inport-1:0]                         head_vec,
  input  logic [no_inport-1:0]                         tail_vec,
  input  logic [no_inport*phit_size-1:0]               indata_vec,
  output logic [no_inport-1:0]                         grant_vec,
  output logic [phit_size-1:0]                         outdata,
  output logic                                         outvalid,
  output logic [floorplusone_log2_no_vc-1:0]           outvc_no,
  input  logic                                         credit_in,
  input  logic [floorplusone_log2_no_vc-1:0]           credit_vc,
  output logic [no_vc-1:0]                             vc_busy_vec,
  output logic                                         credit_err,
  output logic                                         busy
);

  localparam int unsigned IW = floorplusone_log2_no_inport;
  localparam int unsigned VW = floorplusone_log2_no_vc;
  localparam int unsigned CW = floorplusone_log2_buf_size;
  localparam bit          Vct = (switching_method == 2);

  logic [CW-1:0]        credit_q [no_vc];
  logic [CW-1:0]        credit_d [no_vc];
  logic [no_vc-1:0]     lock_q, lock_d;
  logic [IW-1:0]        owner_q [no_vc];
  logic [IW-1:0]        owner_d [no_vc];
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 err_q, err_d;
  logic [phit_size-1:0] outdata_q;
  logic                 outvalid_q;
  logic [VW-1:0]        outvc_q;

  logic [VW-1:0]        req_vc [no_inport];
  logic [phit_size-1:0] in_data [no_inport];
  logic [no_inport-1:0] elig;
  logic                 gnt_found;
  logic [IW-1:0]        gnt_idx;
  logic [VW-1:0]        gnt_vc;

  // Eligibility: look up the requested VC's credit and lock state per inport.
  always_comb begin
    logic [CW-1:0] cred;
    logic          lk;
    logic [IW-1:0] own;
    elig = '0;
    for (int i = 0; i < no_inport; i++) begin
      req_vc[i]  = req_vc_vec[i*VW +: VW];
      in_data[i] = indata_vec[i*phit_size +: phit_size];
      cred = '0;
      lk   = 1'b0;
      own  = '0;
      for (int j = 0; j < no_vc; j++) begin
        if (req_vc[i] == VW'(j)) begin
          cred = credit_q[j];
          lk   = lock_q[j];
          own  = owner_q[j];
        end
      end
      if (req_vec[i] && (req_vc[i] < VW'(no_vc))) begin
        if (lk) begin
          elig[i] = (own == IW'(i)) && (cred != '0);
        end else begin
          elig[i] = head_vec[i] && (Vct ? (cred == CW'(buf_size)) : (cred != '0));
        end
      end
    end
  end

  // Round-robin search starting at ptr_q, wrapping modulo no_inport.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < no_inport; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(no_inport)) idx = idx - int'(no_inport);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
    grant_vec = '0;
    if (gnt_found) grant_vec[gnt_idx] = 1'b1;
    gnt_vc = req_vc[gnt_idx];
    ptr_d  = ptr_q;
    if (gnt_found) ptr_d = (gnt_idx == IW'(no_inport - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_comb begin
    logic dec, inc;
    err_d = err_q;
    for (int j = 0; j < no_vc; j++) begin
      credit_d[j] = credit_q[j];
      lock_d[j]   = lock_q[j];
      owner_d[j]  = owner_q[j];
      dec = gnt_found && (gnt_vc == VW'(j));
      inc = credit_in && (credit_vc == VW'(j));
      if (inc && !dec) begin
        if (credit_q[j] == CW'(buf_size)) err_d = 1'b1;
        else credit_d[j] = credit_q[j] + CW'(1);
      end else if (dec && !inc) begin
        credit_d[j] = credit_q[j] - CW'(1);
      end
      // Tail wins over head so a single-flit packet leaves the VC free.
      if (dec) begin
        if (tail_vec[gnt_idx]) begin
          lock_d[j] = 1'b0;
        end else if (head_vec[gnt_idx]) begin
          lock_d[j]  = 1'b1;
          owner_d[j] = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < no_vc; j++) begin
        credit_q[j] <= CW'(buf_size);
        owner_q[j]  <= '0;
      end
      lock_q     <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      outdata_q  <= '0;
      outvalid_q <= 1'b0;
      outvc_q    <= '0;
    end else begin
      for (int j = 0; j < no_vc; j++) begin
        credit_q[j] <= credit_d[j];
        owner_q[j]  <= owner_d[j];
      end
      lock_q     <= lock_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      outvalid_q <= gnt_found;
      if (gnt_found) begin
        outdata_q <= in_data[gnt_idx];
        outvc_q   <= gnt_vc;
      end
    end
  end

  always_comb begin
    busy = |lock_q;
    for (int j = 0; j < no_vc; j++) begin
      if (credit_q[j] != CW'(buf_size)) busy = 1'b1;
    end
  end

  assign outdata     = outdata_q;
  assign outvalid    = outvalid_q;
  assign outvc_no    = outvc_q;
  assign vc_busy_vec = lock_q;
  assign credit_err  = err_q;

endmodule

// File: tb/tb_credit_vc_outport.sv
// Bench for credit_vc_outport: vector table on a wormhole instance with a scoreboard for the
// link outputs, plus a hand sequence on a VCT instance.
module tb_credit_vc_outport;

  logic        clk, reset;
  logic [6:0]  req_vec, head_vec, tail_vec;
  logic [20:0] req_vc_vec;
  logic [223:0] indata_vec;
  logic        credit_in;
  logic [2:0]  credit_vc;

  logic [6:0]  grant_vec, v_grant_vec;
  logic [31:0] outdata, v_outdata;
  logic        outvalid, v_outvalid;
  logic [2:0]  outvc_no, v_outvc_no;
  logic [3:0]  vc_busy_vec, v_vc_busy_vec;
  logic        credit_err, v_credit_err, busy, v_busy;

  int checks = 0;
  int errors = 0;

  credit_vc_outport #(.switching_method(3)) dut (
    .clk(clk), .reset(reset), .req_vec(req_vec), .req_vc_vec(req_vc_vec),
    .head_vec(head_vec), .tail_vec(tail_vec), .indata_vec(indata_vec),
    .grant_vec(grant_vec), .outdata(outdata), .outvalid(outvalid), .outvc_no(outvc_no),
    .credit_in(credit_in), .credit_vc(credit_vc), .vc_busy_vec(vc_busy_vec),
    .credit_err(credit_err), .busy(busy)
  );

  credit_vc_outport #(.switching_method(2)) dut_vct (
    .clk(clk), .reset(reset), .req_vec(req_vec), .req_vc_vec(req_vc_vec),
    .head_vec(head_vec), .tail_vec(tail_vec), .indata_vec(indata_vec),
    .grant_vec(v_grant_vec), .outdata(v_outdata), .outvalid(v_outvalid),
    .outvc_no(v_outvc_no), .credit_in(credit_in), .credit_vc(credit_vc),
    .vc_busy_vec(v_vc_busy_vec), .credit_err(v_credit_err), .busy(v_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  req;
    logic [20:0] vcs;
    logic [6:0]  head;
    logic [6:0]  tail;
    logic        cin;
    logic [2:0]  cvc;
    logic [6:0]  gnt;
    logic [3:0]  bvec;
    logic        bsy;
    logic        err;
  } vec_t;

  typedef struct {
    logic        v;
    logic [2:0]  vc;
    logic [31:0] d;
  } exp_t;

  vec_t rows[$];
  exp_t sb[$];

  function automatic logic [20:0] vsl(input int i, input int v);
    return 21'(v) << (3 * i);
  endfunction

  function automatic logic [31:0] pat(input int s, input int i);
    return 32'hC000_0000 | (32'(s) << 8) | 32'(i);
  endfunction

  task automatic add(input logic rst, input logic [6:0] req, input logic [20:0] vcs,
                     input logic [6:0] head, input logic [6:0] tail, input logic cin,
                     input logic [2:0] cvc, input logic [6:0] gnt, input logic [3:0] bvec,
                     input logic bsy, input logic err);
    vec_t r;
    r.rst = rst; r.req = req; r.vcs = vcs; r.head = head; r.tail = tail; r.cin = cin;
    r.cvc = cvc; r.gnt = gnt; r.bvec = bvec; r.bsy = bsy; r.err = err;
    rows.push_back(r);
  endtask

  task automatic chk(input string nm, input int s, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, s, act, want);
    end
  endtask

  task automatic drive(input logic [6:0] req, input logic [20:0] vcs, input logic [6:0] head,
                       input logic [6:0] tail, input logic cin, input logic [2:0] cvc);
    req_vec = req; req_vc_vec = vcs; head_vec = head; tail_vec = tail;
    credit_in = cin; credit_vc = cvc;
  endtask

  initial begin
    vec_t  r;
    exp_t  e, got;
    logic [2:0]  last_vc;
    logic [31:0] last_d;
    int gi;
    logic [20:0] three;

    three = vsl(0, 0) | vsl(3, 1) | vsl(5, 2);
    // rst req vcs head tail cin cvc | gnt bvec busy err
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    // single-flit packet, inport 2 on VC1
    add(0, 7'h04, vsl(2, 1), 7'h04, 7'h04, 0, 0,             7'h04, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,                                 0, 0, 0, 0);
    // open packets on VC0/1/2 from inports 0/3/5, then stream body flits
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    add(0, 7'h01, vsl(0, 0), 7'h01, 0, 0, 0,                 7'h01, 4'h1, 1, 0);
    add(0, 7'h08, vsl(3, 1), 7'h08, 0, 0, 0,                 7'h08, 4'h3, 1, 0);
    add(0, 7'h20, vsl(5, 2), 7'h20, 0, 0, 0,                 7'h20, 4'h7, 1, 0);
    for (int k = 0; k < 2; k++) begin
      add(0, 7'h29, three, 0, 0, 0, 0,                       7'h01, 4'h7, 1, 0);
      add(0, 7'h29, three, 0, 0, 0, 0,                       7'h08, 4'h7, 1, 0);
      add(0, 7'h29, three, 0, 0, 0, 0,                       7'h20, 4'h7, 1, 0);
    end
    // wormhole 5-flit packet on VC0 runs out of credit after 4 flits
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    add(0, 7'h40, vsl(6, 0), 7'h40, 0, 0, 0,                 7'h40, 4'h1, 1, 0);
    for (int k = 0; k < 3; k++)
      add(0, 7'h40, vsl(6, 0), 0, 0, 0, 0,                   7'h40, 4'h1, 1, 0);
    add(0, 7'h40, vsl(6, 0), 0, 7'h40, 0, 0,                 0, 4'h1, 1, 0);
    add(0, 7'h40, vsl(6, 0), 0, 7'h40, 1, 0,                 0, 4'h1, 1, 0);
    add(0, 7'h40, vsl(6, 0), 0, 7'h40, 0, 0,                 7'h40, 0, 1, 0);
    // inport 4 head waits while inport 1 owns VC0
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    add(0, 7'h02, vsl(1, 0), 7'h02, 0, 0, 0,                 7'h02, 4'h1, 1, 0);
    add(0, 7'h12, vsl(1, 0) | vsl(4, 0), 7'h10, 0, 1, 0,     7'h02, 4'h1, 1, 0);
    add(0, 7'h12, vsl(1, 0) | vsl(4, 0), 7'h10, 0, 1, 0,     7'h02, 4'h1, 1, 0);
    add(0, 7'h12, vsl(1, 0) | vsl(4, 0), 7'h10, 7'h02, 1, 0, 7'h02, 0, 1, 0);
    add(0, 7'h10, vsl(4, 0), 7'h10, 7'h10, 0, 0,             7'h10, 0, 1, 0);
    // out-of-range VC, credit overflow, sticky error, reset clears locks
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    add(0, 7'h04, vsl(2, 6), 7'h04, 7'h04, 1, 7,             0, 0, 0, 0);
    add(0, 7'h01, vsl(0, 3), 7'h01, 7'h01, 1, 3,             7'h01, 0, 0, 0);
    add(0, 7'h02, vsl(1, 0), 7'h02, 0, 1, 3,                 7'h02, 4'h1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,                                 0, 4'h1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0);
    // two heads for idle VC2: RR winner locks, loser waits for its tail
    add(0, 7'h09, vsl(0, 2) | vsl(3, 2), 7'h09, 0, 0, 0,     7'h01, 4'h4, 1, 0);
    add(0, 7'h09, vsl(0, 2) | vsl(3, 2), 7'h08, 7'h01, 0, 0, 7'h01, 0, 1, 0);
    add(0, 7'h08, vsl(3, 2), 7'h08, 0, 0, 0,                 7'h08, 4'h4, 1, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    indata_vec = '0;
    last_vc = '0;
    last_d  = '0;
    @(posedge clk); #1;

    for (int s = 0; s < rows.size(); s++) begin
      r = rows[s];
      reset = r.rst;
      drive(r.req, r.vcs, r.head, r.tail, r.cin, r.cvc);
      for (int i = 0; i < 7; i++) indata_vec[i*32 +: 32] = pat(s, i);
      if (r.rst) begin
        last_vc = '0;
        last_d  = '0;
        e.v = 1'b0;
      end else if (r.gnt != '0) begin
        gi = 0;
        for (int i = 0; i < 7; i++) if (r.gnt[i]) gi = i;
        last_vc = r.vcs[gi*3 +: 3];
        last_d  = pat(s, gi);
        e.v = 1'b1;
      end else begin
        e.v = 1'b0;
      end
      e.vc = last_vc;
      e.d  = last_d;
      sb.push_back(e);

      @(negedge clk);
      chk("grant_vec", s, 32'(grant_vec), 32'(r.gnt));
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard step %0d: got empty queue want entry", s);
      end else begin
        got = sb.pop_front();
        chk("outvalid", s, 32'(outvalid), 32'(got.v));
        chk("outvc_no", s, 32'(outvc_no), 32'(got.vc));
        chk("outdata", s, outdata, got.d);
      end
      chk("vc_busy_vec", s, 32'(vc_busy_vec), 32'(r.bvec));
      chk("busy", s, 32'(busy), 32'(r.bsy));
      chk("credit_err", s, 32'(credit_err), 32'(r.err));
    end

    // VCT: a head needs a full downstream buffer before it is admitted
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("vct reset outvalid", 100, 32'(v_outvalid), 0);
    chk("vct reset busy", 100, 32'(v_busy), 0);
    drive(7'h01, vsl(0, 2), 7'h01, 7'h01, 0, 0);
    @(negedge clk);
    chk("vct full head grant", 101, 32'(v_grant_vec), 32'h01);
    @(posedge clk); #1;
    chk("vct outvalid", 101, 32'(v_outvalid), 1);
    chk("vct outvc_no", 101, 32'(v_outvc_no), 2);
    drive(7'h08, vsl(3, 2), 7'h08, 0, 0, 0);
    @(negedge clk);
    chk("vct partial head blocked", 102, 32'(v_grant_vec), 0);
    @(posedge clk); #1;
    chk("vct idle outvalid", 102, 32'(v_outvalid), 0);
    drive(7'h08, vsl(3, 2), 7'h08, 0, 1, 2);
    @(negedge clk);
    chk("vct blocked during credit", 103, 32'(v_grant_vec), 0);
    @(posedge clk); #1;
    drive(7'h08, vsl(3, 2), 7'h08, 0, 0, 0);
    @(negedge clk);
    chk("vct head after credit", 104, 32'(v_grant_vec), 32'h08);
    @(posedge clk); #1;
    chk("vct outvalid2", 104, 32'(v_outvalid), 1);
    chk("vct lock", 104, 32'(v_vc_busy_vec), 32'h4);
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
